// File: rtl/sha256_msg_loader_pkg.sv
// Shared constants and types for the byte-serial sha256 message loader.
package sha256_msg_loader_pkg;

  // Largest message that still fits two 512-bit blocks after padding.
  localparam int unsigned MAX_MSG_BYTES = 119;
  localparam int unsigned BLOCK_BITS    = 512;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SETTLE  = 2'd1,
    RESULT  = 2'd2
  } loader_state_t;

  // Message length in bits from a byte count.
  function automatic logic [9:0] bytes_to_bits(input logic [6:0] count);
    return {count, 3'b000};
  endfunction

endpackage

// File: rtl/sha256_msg_loader.sv
// Byte-serial front end for the combinational sha256 core: packs an MSB-first
// byte stream into binary_input/input_length, holds it while the core settles,
// then returns the sampled hash bit over a valid/ready handshake.
module sha256_msg_loader
  import sha256_msg_loader_pkg::*;
#(
  parameter int unsigned MAX_BYTES     = MAX_MSG_BYTES,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic [0:1023] binary_input,
  output logic [0:9]    input_length,
  input  logic          hash_bit,
  output logic          result_valid,
  input  logic          result_ready,
  output logic          result_bit,
  output logic          overflow_err,
  output logic          busy
);

  localparam logic [6:0]  MaxCount   = 7'(MAX_BYTES);
  localparam logic [15:0] SettleLoad = 16'(SETTLE_CYCLES - 1);

  loader_state_t r_state, w_state_d;
  logic [0:1023] r_data, w_data_d;
  logic [6:0]    r_count, w_count_d;
  logic [15:0]   r_settle, w_settle_d;
  logic          r_ovf, w_ovf_d;
  logic          r_valid, w_valid_d;
  logic          r_bit, w_bit_d;
  logic          r_busy, w_busy_d;
  logic          w_accept;
  logic [9:0]    w_lane;

  // in_ready depends only on the registered state, never on in_valid.
  assign in_ready = (r_state == COLLECT);
  assign w_accept = in_valid && in_ready;
  // Bit offset of the next free byte lane; bit 0 of the lane takes in_data[7].
  assign w_lane   = bytes_to_bits(r_count);

  // Next-state logic for the collect / settle / result sequence.
  always_comb begin
    w_state_d  = r_state;
    w_data_d   = r_data;
    w_count_d  = r_count;
    w_settle_d = r_settle;
    w_ovf_d    = r_ovf;
    w_valid_d  = r_valid;
    w_bit_d    = r_bit;
    unique case (r_state)
      COLLECT: begin
        if (w_accept) begin
          if (r_count < MaxCount) begin
            w_data_d[w_lane +: 8] = in_data;
            w_count_d             = r_count + 7'd1;
          end else begin
            // Message full: drop the byte but remember that we did.
            w_ovf_d = 1'b1;
          end
          // A dropped last byte still terminates the message.
          if (in_last) begin
            w_state_d  = SETTLE;
            w_settle_d = SettleLoad;
          end
        end
      end
      SETTLE: begin
        if (r_settle == 16'd0) begin
          w_bit_d   = hash_bit;
          w_valid_d = 1'b1;
          w_state_d = RESULT;
        end else begin
          w_settle_d = r_settle - 16'd1;
        end
      end
      RESULT: begin
        if (r_valid && result_ready) begin
          // result_bit is deliberately kept until the next capture.
          w_valid_d = 1'b0;
          w_data_d  = '0;
          w_count_d = 7'd0;
          w_ovf_d   = 1'b0;
          w_state_d = COLLECT;
        end
      end
      default: begin
        w_state_d = COLLECT;
      end
    endcase
    w_busy_d = (w_state_d != COLLECT);
  end

  // State and output registers; reset clears any partial message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= COLLECT;
      r_data   <= '0;
      r_count  <= 7'd0;
      r_settle <= 16'd0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_bit    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_data   <= w_data_d;
      r_count  <= w_count_d;
      r_settle <= w_settle_d;
      r_ovf    <= w_ovf_d;
      r_valid  <= w_valid_d;
      r_bit    <= w_bit_d;
      r_busy   <= w_busy_d;
    end
  end

  assign binary_input = r_data;
  assign input_length = bytes_to_bits(r_count);
  assign result_valid = r_valid;
  assign result_bit   = r_bit;
  assign overflow_err = r_ovf;
  assign busy         = r_busy;

endmodule

// File: tb/tb_sha256_msg_loader.sv
// Self-checking bench for sha256_msg_loader; hash_bit is driven by the bench
// so the sampling instant can be pinned down exactly.
module tb_sha256_msg_loader;

  localparam int unsigned Settle = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          in_last = 1'b0;
  logic [0:1023] binary_input;
  logic [0:9]    input_length;
  logic          hash_bit = 1'b0;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic          result_bit;
  logic          overflow_err;
  logic          busy;

  always #5 clk = ~clk;

  sha256_msg_loader #(
    .MAX_BYTES    (119),
    .SETTLE_CYCLES(Settle)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .binary_input(binary_input),
    .input_length(input_length),
    .hash_bit    (hash_bit),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_bit  (result_bit),
    .overflow_err(overflow_err),
    .busy        (busy)
  );

  typedef struct {
    int         n;
    logic [7:0] base;
    logic [7:0] step;
    logic       hb;
    int         exp_len;
    logic       exp_ovf;
  } vec_t;

  typedef struct {
    logic [0:1023] bin;
    logic [9:0]    len;
    logic          ovf;
    logic          hb;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[5];
  int   errs = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bin(input string name, input logic [0:1023] exp);
    logic [0:1023] act;
    act = binary_input;
    checks++;
    if (act !== exp) begin
      errs++;
      for (int i = 0; i < 128; i++) begin
        if (act[8*i +: 8] !== exp[8*i +: 8]) begin
          $display("FAIL %s: byte %0d got %0h expected %0h", name, i, act[8*i +: 8],
                   exp[8*i +: 8]);
          break;
        end
      end
    end
  endtask

  // Reference packing: first 119 bytes land MSB-first, later ones are dropped.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int   cnt;
    logic [7:0] b;
    e.bin = '0;
    e.ovf = 1'b0;
    e.hb  = v.hb;
    cnt   = 0;
    for (int k = 0; k < v.n; k++) begin
      b = v.base + 8'(k) * v.step;
      if (cnt < 119) begin
        e.bin[8*cnt +: 8] = b;
        cnt++;
      end else begin
        e.ovf = 1'b1;
      end
    end
    e.len = 10'(cnt * 8);
    return e;
  endfunction

  // Drives the bytes back-to-back; returns at the negedge of cycle T+1.
  task automatic drive_bytes(input vec_t v, input string tag);
    for (int k = 0; k < v.n; k++) begin
      @(negedge clk);
      chk($sformatf("%s in_ready byte %0d", tag, k), 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = v.base + 8'(k) * v.step;
      in_last  = (k == v.n - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t  e;
    exp_t  got;
    int    lat;
    string tag;
    tag = $sformatf("v%0d", idx);
    e   = model(v);
    sb_q.push_back(e);
    hash_bit = ~v.hb;
    drive_bytes(v, tag);
    // Cycle T+1: core inputs frozen, loader busy.
    chk({tag, " settle in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " settle busy"}, 32'(busy), 32'd1);
    chk({tag, " settle len"}, 32'(input_length), 32'(v.exp_len));
    chk({tag, " settle ovf"}, 32'(overflow_err), 32'(v.exp_ovf));
    chk_bin({tag, " settle bin"}, e.bin);
    // hash_bit carries the right value only in the last SETTLE cycle.
    lat = 0;
    while (!result_valid && lat < 20) begin
      hash_bit = (lat == Settle - 1) ? v.hb : ~v.hb;
      @(negedge clk);
      lat++;
    end
    hash_bit = ~v.hb;
    chk({tag, " result latency"}, 32'(lat), 32'(Settle));
    if (!result_valid) begin
      checks++;
      errs++;
      $display("FAIL %s result_valid timeout: got 0 expected 1", tag);
    end
    if (sb_q.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL %s scoreboard empty: got 0 expected 1 entries", tag);
    end else begin
      got = sb_q.pop_front();
      chk({tag, " result_bit"}, 32'(result_bit), 32'(got.hb));
      chk({tag, " result len"}, 32'(input_length), 32'(got.len));
      chk({tag, " result ovf"}, 32'(overflow_err), 32'(got.ovf));
      chk_bin({tag, " result bin"}, got.bin);
    end
    // Backpressure: bytes offered in RESULT must be ignored.
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = 8'hff;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("%s bp valid %0d", tag, i), 32'(result_valid), 32'd1);
      chk($sformatf("%s bp in_ready %0d", tag, i), 32'(in_ready), 32'd0);
      chk($sformatf("%s bp len %0d", tag, i), 32'(input_length), 32'(e.len));
    end
    in_valid     = 1'b0;
    in_last      = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({tag, " post in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " post valid"}, 32'(result_valid), 32'd0);
    chk({tag, " post busy"}, 32'(busy), 32'd0);
    chk({tag, " post len"}, 32'(input_length), 32'd0);
    chk({tag, " post ovf"}, 32'(overflow_err), 32'd0);
    chk({tag, " post result_bit held"}, 32'(result_bit), 32'(v.hb));
    chk_bin({tag, " post bin"}, '0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " valid"}, 32'(result_valid), 32'd0);
    chk({tag, " result_bit"}, 32'(result_bit), 32'd0);
    chk({tag, " len"}, 32'(input_length), 32'd0);
    chk({tag, " ovf"}, 32'(overflow_err), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk_bin({tag, " bin"}, '0);
  endtask

  initial begin
    vec_t v;
    //          n    base    step   hb    len  ovf
    tbl[0] = '{  3, 8'h61, 8'h01, 1'b1,  24, 1'b0};  // "abc"
    tbl[1] = '{  1, 8'h00, 8'h00, 1'b0,   8, 1'b0};  // single zero byte
    tbl[2] = '{ 10, 8'ha5, 8'h13, 1'b1,  80, 1'b0};
    tbl[3] = '{119, 8'h01, 8'h01, 1'b0, 952, 1'b0};  // exactly full
    tbl[4] = '{121, 8'h80, 8'h03, 1'b1, 952, 1'b1};  // two bytes dropped

    #1;
    chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i], i);
    end

    // Reset in the second SETTLE cycle must discard the partial message.
    v = '{3, 8'h11, 8'h22, 1'b1, 24, 1'b0};
    drive_bytes(v, "rst");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{1, 8'h5a, 8'h00, 1'b1, 8, 1'b0}, 5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
